// File: rtl/pulse_meter3_if.sv
// pulse_meter3_if: pulse channel inputs and measurement results of pulse_meter3
interface pulse_meter3_if;
    logic C1, C2, C3;
    logic [4:0] Period1, Period2, Period3;
    logic [4:0] Width1, Width2, Width3;
    logic [4:0] Phase2, Phase3;
    logic VALID1, VALID2, VALID3;
    logic OVF1, OVF2, OVF3;
    modport master (
        output C1, C2, C3,
        input Period1, Period2, Period3, Width1, Width2, Width3, Phase2, Phase3,
        input VALID1, VALID2, VALID3, OVF1, OVF2, OVF3
    );
    modport slave (
        input C1, C2, C3,
        output Period1, Period2, Period3, Width1, Width2, Width3, Phase2, Phase3,
        output VALID1, VALID2, VALID3, OVF1, OVF2, OVF3
    );
endinterface

// File: rtl/pulse_meter3.sv
// pulse_meter3: per-channel period/width meter with C1-referenced phase of C2/C3
module pulse_meter3 (
    input logic clk,
    input logic RST_N,
    input logic CLR,
    pulse_meter3_if.slave pm
);
    typedef enum logic {IDLE, MEAS} state_t;
    logic [2:0] c, prev, rise, fall, ph_sat;
    assign c = {pm.C3, pm.C2, pm.C1};
    assign rise = c & ~prev;
    assign fall = ~c & prev;
    assign ph_sat[0] = 1'b0;
    // on CLR prev follows Cx as well, so a level already high is not a new edge
    always_ff @(posedge clk or negedge RST_N)
        if (!RST_N) prev <= '0;
        else prev <= c;
    for (genvar g = 0; g < 3; g++) begin : ch
        state_t st, st_nx;
        logic [4:0] cnt_p, cnt_w, per, wid;
        logic valid, ovf, sat_p, sat_w;
        assign sat_p = cnt_p == 5'd31;
        assign sat_w = cnt_w == 5'd31;
        always_comb begin
            st_nx = st;
            if (st == IDLE && rise[g]) st_nx = MEAS;
        end
        always_ff @(posedge clk or negedge RST_N)
            if (!RST_N) st <= IDLE;
            else st <= CLR ? IDLE : st_nx;
        always_ff @(posedge clk or negedge RST_N)
            if (!RST_N) begin
                cnt_p <= '0;
                cnt_w <= '0;
                per <= '0;
                wid <= '0;
                valid <= 1'b0;
                ovf <= 1'b0;
            end else if (CLR) begin
                cnt_p <= '0;
                cnt_w <= '0;
                per <= '0;
                wid <= '0;
                valid <= 1'b0;
                ovf <= 1'b0;
            end else begin
                valid <= rise[g] && st == MEAS;
                if (rise[g]) begin
                    cnt_p <= 5'd1;
                    cnt_w <= 5'd1;
                    if (st == MEAS) per <= cnt_p;
                end else begin
                    if (st == MEAS) cnt_p <= sat_p ? cnt_p : cnt_p + 5'd1;
                    if (c[g]) cnt_w <= sat_w ? cnt_w : cnt_w + 5'd1;
                end
                if (fall[g] && st == MEAS) wid <= cnt_w;
                if ((!rise[g] && ((st == MEAS && sat_p) || (c[g] && sat_w))) || ph_sat[g]) ovf <= 1'b1;
            end
    end
    for (genvar g = 1; g < 3; g++) begin : ph
        logic [4:0] cnt, phase, inc;
        logic arm;
        assign inc = cnt == 5'd31 ? cnt : cnt + 5'd1;
        assign ph_sat[g] = arm && cnt == 5'd31 && !rise[0];
        // capture the incremented value so Phasex counts the cycles between the two edges
        always_ff @(posedge clk or negedge RST_N)
            if (!RST_N) begin
                cnt <= '0;
                phase <= '0;
                arm <= 1'b0;
            end else if (CLR) begin
                cnt <= '0;
                phase <= '0;
                arm <= 1'b0;
            end else if (rise[0]) begin
                cnt <= '0;
                arm <= !rise[g];
                if (rise[g]) phase <= '0;
            end else if (arm) begin
                cnt <= inc;
                if (rise[g]) begin
                    phase <= inc;
                    arm <= 1'b0;
                end
            end
    end
    assign pm.Period1 = ch[0].per;
    assign pm.Period2 = ch[1].per;
    assign pm.Period3 = ch[2].per;
    assign pm.Width1 = ch[0].wid;
    assign pm.Width2 = ch[1].wid;
    assign pm.Width3 = ch[2].wid;
    assign pm.VALID1 = ch[0].valid;
    assign pm.VALID2 = ch[1].valid;
    assign pm.VALID3 = ch[2].valid;
    assign pm.OVF1 = ch[0].ovf;
    assign pm.OVF2 = ch[1].ovf;
    assign pm.OVF3 = ch[2].ovf;
    assign pm.Phase2 = ph[1].phase;
    assign pm.Phase3 = ph[2].phase;
endmodule

// File: tb/tb_pulse_meter3.sv
// tb_pulse_meter3: directed self-checking bench for pulse_meter3
module tb_pulse_meter3;
    logic clk = 1'b0;
    logic RST_N = 1'b0;
    logic CLR = 1'b0;
    int checks = 0;
    int errors = 0;
    pulse_meter3_if pm();
    pulse_meter3 dut (.clk(clk), .RST_N(RST_N), .CLR(CLR), .pm(pm));
    always #5 clk = ~clk;

    task automatic cyc(input logic a, input logic b, input logic d);
        pm.C1 = a;
        pm.C2 = b;
        pm.C3 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic c3);
        RST_N = 1'b0;
        CLR = 1'b0;
        pm.C1 = 1'b0;
        pm.C2 = 1'b0;
        pm.C3 = c3;
        repeat (2) @(posedge clk);
        #1 RST_N = 1'b1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        pm.C1 = 1'b1;
        pm.C2 = 1'b0;
        pm.C3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pm.Period1, pm.Period2, pm.Period3, pm.Width1, pm.Width2, pm.Width3, pm.Phase2, pm.Phase3} !== 40'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", {pm.Period1, pm.Period2, pm.Period3, pm.Width1, pm.Width2, pm.Width3, pm.Phase2, pm.Phase3});
        end
        checks++;
        if ({pm.VALID1, pm.VALID2, pm.VALID3, pm.OVF1, pm.OVF2, pm.OVF3} !== 6'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {pm.VALID1, pm.VALID2, pm.VALID3, pm.OVF1, pm.OVF2, pm.OVF3});
        end
    endtask

    task automatic test_period_width;
        do_reset(1'b0);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 8; i++) begin
                cyc(i < 3, 1'b0, 1'b0);
                if (i == 0) begin
                    checks++;
                    if (pm.VALID1 !== (p > 0)) begin
                        errors++;
                        $display("FAIL pw_valid1 p=%0d: got %b expected %b", p, pm.VALID1, p > 0);
                    end
                    checks++;
                    if (pm.Period1 !== (p > 0 ? 5'd8 : 5'd0)) begin
                        errors++;
                        $display("FAIL pw_period1 p=%0d: got %0d expected %0d", p, pm.Period1, p > 0 ? 8 : 0);
                    end
                end
                if (i == 1) begin
                    checks++;
                    if (pm.VALID1 !== 1'b0) begin
                        errors++;
                        $display("FAIL pw_valid1_oneshot p=%0d: got %b expected 0", p, pm.VALID1);
                    end
                end
                if (i == 3) begin
                    checks++;
                    if (pm.Width1 !== 5'd3) begin
                        errors++;
                        $display("FAIL pw_width1 p=%0d: got %0d expected 3", p, pm.Width1);
                    end
                end
            end
        checks++;
        if (pm.OVF1 !== 1'b0) begin
            errors++;
            $display("FAIL pw_ovf1: got %b expected 0", pm.OVF1);
        end
    endtask

    task automatic test_phase;
        do_reset(1'b0);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 8; i++) cyc(i < 3, i >= 2 && i < 5, i >= 5);
        checks++;
        if (pm.Phase2 !== 5'd2) begin
            errors++;
            $display("FAIL ph_phase2: got %0d expected 2", pm.Phase2);
        end
        checks++;
        if (pm.Phase3 !== 5'd5) begin
            errors++;
            $display("FAIL ph_phase3_d5: got %0d expected 5", pm.Phase3);
        end
        checks++;
        if (pm.Period2 !== 5'd8) begin
            errors++;
            $display("FAIL ph_period2: got %0d expected 8", pm.Period2);
        end
        checks++;
        if (pm.Width2 !== 5'd3) begin
            errors++;
            $display("FAIL ph_width2: got %0d expected 3", pm.Width2);
        end
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 8; i++) cyc(i < 3, i >= 2 && i < 5, i < 3);
        checks++;
        if (pm.Phase3 !== 5'd0) begin
            errors++;
            $display("FAIL ph_phase3_d0: got %0d expected 0", pm.Phase3);
        end
        checks++;
        if (pm.Period3 !== 5'd8) begin
            errors++;
            $display("FAIL ph_period3: got %0d expected 8", pm.Period3);
        end
        checks++;
        if (pm.Phase2 !== 5'd2) begin
            errors++;
            $display("FAIL ph_phase2_hold: got %0d expected 2", pm.Phase2);
        end
    endtask

    task automatic test_overflow;
        do_reset(1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (40) cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (pm.Width2 !== 5'd1) begin
            errors++;
            $display("FAIL ovf_width2: got %0d expected 1", pm.Width2);
        end
        checks++;
        if (pm.OVF2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", pm.OVF2);
        end
        cyc(1'b0, 1'b1, 1'b0);
        checks++;
        if (pm.Period2 !== 5'd31) begin
            errors++;
            $display("FAIL ovf_period2_sat: got %0d expected 31", pm.Period2);
        end
        checks++;
        if (pm.VALID2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_valid2: got %b expected 1", pm.VALID2);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (pm.OVF2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", pm.OVF2);
        end
        checks++;
        if ({pm.OVF1, pm.OVF3} !== 2'b00) begin
            errors++;
            $display("FAIL ovf_independent: got %b expected 00", {pm.OVF1, pm.OVF3});
        end
        CLR = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        CLR = 1'b0;
        checks++;
        if ({pm.OVF2, pm.Period2, pm.Width2} !== 11'd0) begin
            errors++;
            $display("FAIL ovf_clr: got ovf=%b period=%0d width=%0d expected all 0", pm.OVF2, pm.Period2, pm.Width2);
        end
    endtask

    task automatic test_clr_edge;
        do_reset(1'b0);
        for (int k = 0; k < 16; k++) cyc(k % 8 < 3, 1'b0, 1'b0);
        CLR = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        CLR = 1'b0;
        checks++;
        if ({pm.VALID1, pm.Period1, pm.Width1} !== 11'd0) begin
            errors++;
            $display("FAIL clr_edge: got valid=%b period=%0d width=%0d expected all 0", pm.VALID1, pm.Period1, pm.Width1);
        end
        for (int i = 1; i < 8; i++) cyc(i < 3, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if ({pm.VALID1, pm.Period1} !== 6'd0) begin
            errors++;
            $display("FAIL clr_first_rise: got valid=%b period=%0d expected 0/0", pm.VALID1, pm.Period1);
        end
        for (int i = 1; i < 8; i++) cyc(i < 3, 1'b0, 1'b0);
        checks++;
        if (pm.Width1 !== 5'd3) begin
            errors++;
            $display("FAIL clr_width1: got %0d expected 3", pm.Width1);
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if ({pm.VALID1, pm.Period1} !== {1'b1, 5'd8}) begin
            errors++;
            $display("FAIL clr_second_rise: got valid=%b period=%0d expected 1/8", pm.VALID1, pm.Period1);
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b0);
        for (int k = 0; k < 16; k++) cyc(k % 8 < 3, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({pm.VALID1, pm.Period1, pm.Width1} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b period=%0d width=%0d expected all 0", pm.VALID1, pm.Period1, pm.Width1);
        end
        pm.C1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(i < 3, 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if (pm.VALID1 !== 1'b0) begin
                    errors++;
                    $display("FAIL async_first_rise: got valid=%b expected 0", pm.VALID1);
                end
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if ({pm.VALID1, pm.Period1} !== {1'b1, 5'd8}) begin
            errors++;
            $display("FAIL async_second_rise: got valid=%b period=%0d expected 1/8", pm.VALID1, pm.Period1);
        end
    endtask

    task automatic test_hold_high;
        logic seen_valid;
        seen_valid = 1'b0;
        do_reset(1'b1);
        for (int k = 0; k < 31; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            seen_valid |= pm.VALID3;
        end
        checks++;
        if (pm.OVF3 !== 1'b0) begin
            errors++;
            $display("FAIL hold_ovf3_early: got %b expected 0", pm.OVF3);
        end
        cyc(1'b0, 1'b0, 1'b1);
        seen_valid |= pm.VALID3;
        checks++;
        if (pm.OVF3 !== 1'b1) begin
            errors++;
            $display("FAIL hold_ovf3: got %b expected 1", pm.OVF3);
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_valid3: got %b expected 0", seen_valid);
        end
        checks++;
        if ({pm.Width3, pm.Period3} !== 10'd0) begin
            errors++;
            $display("FAIL hold_width3: got width=%0d period=%0d expected 0/0", pm.Width3, pm.Period3);
        end
    endtask

    initial begin
        test_reset;
        test_period_width;
        test_phase;
        test_overflow;
        test_clr_edge;
        test_async_reset;
        test_hold_high;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_meter3.md
PULSE_METER3 -- requirements
Module: pulse_meter3

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-002 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-003 SHALL have port CLR  input  1  synchronous clear of all measurement results, VALID and OVF flags (active high).
REQ-004 SHALL have ports C1, C2, C3  input  1 each  pulse channels under measurement, synchronous to clk.
REQ-005 SHALL have ports Period1, Period2, Period3  output  5 each  cycles between consecutive rising edges of Cx.
REQ-006 SHALL have ports Width1, Width2, Width3  output  5 each  cycles Cx was high in last complete pulse.
REQ-007 SHALL have ports Phase2, Phase3  output  5 each  cycles from latest C1 rising edge to next Cx rising edge.
REQ-008 SHALL have ports VALID1, VALID2, VALID3  output  1 each  one-cycle strobe when Periodx updates.
REQ-009 SHALL have ports OVF1, OVF2, OVF3  output  1 each  sticky saturation flag per channel.

Function
REQ-010 SHALL register each Cx into prev_x every cycle; rise_x = Cx & ~prev_x, fall_x = ~Cx & prev_x.
REQ-011 SHALL keep per channel a 2-state FSM: IDLE (no rising edge seen yet) -> MEAS on first rise_x; MEAS held until reset or CLR.
REQ-012 SHALL on every rise_x load period counter cnt_p_x <= 1 and width counter cnt_w_x <= 1.
REQ-013 SHALL otherwise increment cnt_p_x every cycle while in MEAS, and cnt_w_x every cycle while Cx = 1.
REQ-014 SHALL on rise_x in MEAS capture Periodx <= cnt_p_x and assert VALIDx for exactly that one cycle; on rise_x in IDLE no capture and no VALIDx.
REQ-015 SHALL on fall_x in MEAS capture Widthx <= cnt_w_x; Widthx independent of VALIDx.
REQ-016 SHALL saturate all counters at 31 (no wrap); any counter reaching 31 and attempting to increment sets OVFx (Phase counters set OVF of target channel).
REQ-017 SHALL on saturation still capture 31 at the following edge.
REQ-018 SHALL run phase counter ph_x (x=2,3): rise_1 loads ph_x <= 0 and arms it; armed counter increments each cycle; rise_x while armed captures Phasex <= ph_x and disarms.
REQ-019 SHALL when rise_1 and rise_x occur in the same cycle capture Phasex <= 0.
REQ-020 SHALL ignore rise_x while phase counter unarmed (Phasex holds).
REQ-021 SHALL on CLR: all outputs and counters to 0, all FSMs to IDLE, phase counters disarmed, prev_x <= Cx; CLR takes priority over any simultaneous edge.
REQ-022 SHALL have latency: outputs update at the same posedge that samples the detecting edge condition (registered outputs, no combinational path from Cx).
REQ-023 SHALL treat all three channels fully independently except the shared C1 phase reference.

Reset
REQ-024 SHALL on RST_N = 0 asynchronously force all outputs to 0, all FSMs to IDLE, all counters to 0, prev_x to 0, phase counters disarmed.
REQ-025 SHALL after reset release treat a Cx already high at the first sampled posedge as a rising edge.
REQ-026 SHALL on reset assertion mid-pulse discard the partial measurement; no VALIDx after release until two rise_x.

Verification
REQ-027 C1 periodic high 3 / low 5 cycles -> after second rising edge Period1 = 8, VALID1 one cycle; after each fall Width1 = 3; OVF1 = 0.
REQ-028 C1 period 8, C2 same waveform delayed 2 cycles, C3 delayed 0 -> Phase2 = 2, Phase3 = 0, Period2 = Period3 = 8.
REQ-029 C2 single rise then held low 40 cycles then rise -> Period2 = 31, OVF2 = 1, sticky until CLR.
REQ-030 CLR asserted in same cycle as rise_1 during steady period-8 run -> all outputs 0, VALID1 not asserted; Period1 = 8 again only after two further rises.
REQ-031 RST_N pulsed low mid-pulse (C1 high 2 of 3 cycles) asynchronously -> outputs 0 immediately without clock; first VALID1 after release at second rising edge.
REQ-032 C3 held constant 1 from reset release -> single rise detected at first posedge, no VALID3, Width3 unchanged (0), cnt_w3 saturates and OVF3 = 1 after 31 cycles.
